video_stream_gen: RTL
=====================

VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter LINE_SIZE_MAX, default 1024, maximum active pixels per line and maximum lines per frame.
REQ-003 SHALL have parameter DE_I_PERIOD, default 0: 0 or 1 means one pixel per clock; N>=2 means one pixel every N clocks.
REQ-004 SHALL have ports clk, input, 1, single clock; rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports enable, input, 1, run request.
REQ-006 SHALL have port pattern, input, 2, pattern select.
REQ-007 SHALL have ports pix_count and line_count, input, clog2(LINE_SIZE_MAX)+1 each, active pixels per line and active lines per frame.
REQ-008 SHALL have ports hblank and vblank, input, 16 each, inter-line and inter-frame gap in clocks.
REQ-009 SHALL have ports do_o, output, DATA_WIDTH, pixel; de_o, hs_o, vs_o, output, 1 each, stream strobes compatible with the team's 3x3 filter inputs.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, VBLANK, LINE, HBLANK.
REQ-012 IDLE->VBLANK when enable=1; pattern, pix_count, line_count, hblank and vblank are latched on this transition and held for the whole frame.
REQ-013 pix_count and line_count values below 3 SHALL be latched as 3; values above LINE_SIZE_MAX SHALL be latched as LINE_SIZE_MAX.
REQ-014 VBLANK SHALL last max(vblank,1) clocks, then go to LINE with x=0 and y=0.
REQ-015 LINE SHALL emit exactly pix_count pixels, spaced per DE_I_PERIOD, then go to HBLANK, or to VBLANK/IDLE after the last line.
REQ-016 HBLANK SHALL last max(hblank,1) clocks, then go to LINE with y+1.
REQ-017 After the last pixel of the last line, the FSM SHALL go to VBLANK if enable=1, otherwise to IDLE; enable falling mid-frame SHALL never truncate a frame.
REQ-018 vs_o SHALL be high from the first de_o of line 0 through the last de_o of the last line inclusive, and low in VBLANK and IDLE.
REQ-019 hs_o SHALL be high from the first to the last de_o of each line inclusive, including gap clocks when DE_I_PERIOD>=2.
REQ-020 For DE_I_PERIOD N>=2, de_o SHALL pulse one clock, the first pulse occurring on the first LINE clock, and then every N clocks.
REQ-021 Pattern 0 SHALL output x[DATA_WIDTH-1:0] (horizontal ramp).
REQ-022 Pattern 1 SHALL output y[DATA_WIDTH-1:0] (vertical ramp).
REQ-023 Pattern 2 SHALL output a checker: all-ones when x[3]^y[3]=1, otherwise 0.
REQ-024 Pattern 3 SHALL output a per-frame pixel counter that starts at 0 and wraps modulo 2^DATA_WIDTH.
REQ-025 do_o SHALL be 0 whenever de_o=0.
REQ-026 All outputs SHALL be registered, with do_o, de_o, hs_o and vs_o aligned on the same clock.
REQ-027 The first de_o SHALL occur exactly max(vblank,1)+1 clocks after the clock edge that samples enable=1 in IDLE.

Reset
REQ-028 rst=0 SHALL force, asynchronously, the FSM to IDLE, all counters to 0, and do_o, de_o, hs_o, vs_o and busy to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further de_o; after release, a new frame starts only via REQ-012.

Structure
REQ-030 The FSM state encoding and pattern codes SHALL live in a shared video package (video_pkg) reused by the team's stream blocks.
REQ-031 Pattern generation SHALL be one sub-module, video_pattern_gen, taking x, y, the frame counter and pattern, and returning one registered pixel.

Verification
REQ-032 Case: DE_I_PERIOD=0, 8x4, hblank=2, vblank=3, pattern 0, enable pulsed once -> 32 de_o; each line carries do_o 0..7; hs_o high 8 clocks per line; vs_o high 38 clocks; first de_o 4 clocks after enable; busy low afterwards.
REQ-033 Case: DE_I_PERIOD=3, 4x3 -> de_o pulses every 3 clocks; hs_o high 10 clocks per line; 12 pixels total.
REQ-034 Case: pix_count=1, line_count=0 -> a 3x3 frame of 9 pixels is produced.
REQ-035 Case: enable dropped during line 1 of 4 -> the frame completes with all 4 lines, then IDLE; pattern changed mid-frame has no effect until the next frame.
REQ-036 Case: rst asserted during LINE -> all outputs 0 the same cycle; no de_o until enable is sampled again after release.
REQ-037 Case: pattern 3, 16x16, DATA_WIDTH=8, two consecutive frames -> each frame outputs 0..255 and the second frame restarts at 0.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: FSM states, pattern codes and helpers shared by the video stream blocks.
package video_pkg;

    typedef enum logic [1:0] {IDLE, VBLANK, LINE, HBLANK} state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_COUNT = 2'd3;

    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: turns the current x/y position and frame pixel count into one registered pixel.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CW = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  de,
    input  logic [CW-1:0]         x,
    input  logic [CW-1:0]         y,
    input  logic [DATA_WIDTH-1:0] fcnt,
    input  logic [1:0]            pattern,
    output logic [DATA_WIDTH-1:0] pix
);

    logic                  chk;
    logic [DATA_WIDTH-1:0] px;

    assign chk = |((x ^ y) & CW'(8));

    always_comb
        px = (pattern == PAT_HRAMP) ? DATA_WIDTH'(x) :
             (pattern == PAT_VRAMP) ? DATA_WIDTH'(y) :
             (pattern == PAT_CHECK) ? {DATA_WIDTH{chk}} : fcnt;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            pix <= '0;
        else
            pix <= de ? px : '0;

endmodule

// File: rtl/video_stream_gen.sv
// video_stream_gen: test-pattern video source producing de/hs/vs framed pixel streams.
// Frame geometry and pattern are latched at frame start and held until the frame ends.
module video_stream_gen
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_SIZE_MAX = 1024,
    parameter int DE_I_PERIOD = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [1:0]                       pattern,
    input  logic [$clog2(LINE_SIZE_MAX):0]   pix_count,
    input  logic [$clog2(LINE_SIZE_MAX):0]   line_count,
    input  logic [15:0]                      hblank,
    input  logic [15:0]                      vblank,
    output logic [DATA_WIDTH-1:0]            do_o,
    output logic                             de_o,
    output logic                             hs_o,
    output logic                             vs_o,
    output logic                             busy
);

    localparam int CW = $clog2(LINE_SIZE_MAX) + 1;
    localparam int P = (DE_I_PERIOD < 2) ? 1 : DE_I_PERIOD;
    localparam int PW = $clog2(P + 1);

    state_t                state;
    logic [CW-1:0]         x, y, pix_l, line_l;
    logic [15:0]           hb_l, vb_l, cnt;
    logic [1:0]            pat_l;
    logic [PW-1:0]         ph;
    logic [DATA_WIDTH-1:0] fcnt;
    logic                  emit, last_px, frame_end, start;

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
        return (v < CW'(3)) ? CW'(3) : (v > CW'(LINE_SIZE_MAX)) ? CW'(LINE_SIZE_MAX) : v;
    endfunction

    assign emit      = (state == LINE) && (ph == '0);
    assign last_px   = x == pix_l - CW'(1);
    assign frame_end = emit && last_px && (y == line_l - CW'(1));
    // a new frame may start straight from the last pixel of the previous one
    assign start     = enable && ((state == IDLE) || frame_end);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            pix_l  <= '0;
            line_l <= '0;
            hb_l   <= '0;
            vb_l   <= '0;
            cnt    <= '0;
            pat_l  <= '0;
            ph     <= '0;
            fcnt   <= '0;
            de_o   <= 1'b0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            de_o <= emit;
            hs_o <= state == LINE;
            vs_o <= (state == LINE) || (state == HBLANK);
            if (start) begin
                state  <= VBLANK;
                pat_l  <= pattern;
                pix_l  <= clamp(pix_count);
                line_l <= clamp(line_count);
                hb_l   <= at_least_one(hblank);
                vb_l   <= at_least_one(vblank);
                cnt    <= '0;
                fcnt   <= '0;
                busy   <= 1'b1;
            end else
                case (state)
                    VBLANK:
                        if (cnt == vb_l - 16'd1) begin
                            state <= LINE;
                            x     <= '0;
                            y     <= '0;
                            ph    <= '0;
                        end else
                            cnt <= cnt + 16'd1;
                    LINE: begin
                        if (emit)
                            fcnt <= fcnt + DATA_WIDTH'(1);
                        if (emit && last_px) begin
                            cnt   <= '0;
                            state <= frame_end ? IDLE : HBLANK;
                            busy  <= !frame_end;
                        end else if (ph == PW'(P - 1)) begin
                            ph <= '0;
                            x  <= x + CW'(1);
                        end else
                            ph <= ph + PW'(1);
                    end
                    HBLANK:
                        if (cnt == hb_l - 16'd1) begin
                            state <= LINE;
                            x     <= '0;
                            y     <= y + CW'(1);
                            ph    <= '0;
                        end else
                            cnt <= cnt + 16'd1;
                    default: ;
                endcase
        end

    video_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_pat (
        .clk     (clk),
        .rst     (rst),
        .de      (emit),
        .x       (x),
        .y       (y),
        .fcnt    (fcnt),
        .pattern (pat_l),
        .pix     (do_o)
    );

endmodule
